// File: rtl/alveo_hls4ml_mul_share_pkg.sv
// rtl/alveo_hls4ml_mul_share_pkg.sv - widths, stage record and arithmetic helpers for the shared multiplier
package alveo_hls4ml_mul_share_pkg;

  localparam int A_W      = 16;
  localparam int B_W      = 14;
  localparam int P_W      = 30;
  localparam int LAT      = 4;
  localparam int ID_MAX_W = 3;

  localparam logic signed [P_W-1:0] SAT_MAX = 32767;
  localparam logic signed [P_W-1:0] SAT_MIN = -32768;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
    logic [P_W-1:0]      p;
  } stage_t;

  function automatic logic [P_W-1:0] mul_ab(input logic signed [A_W-1:0] a,
                                            input logic signed [B_W-1:0] b);
    logic signed [P_W-1:0] ea;
    logic signed [P_W-1:0] eb;
    ea = P_W'(a);
    eb = P_W'(b);
    return ea * eb;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [P_W-1:0] x);
    if (x > SAT_MAX) return 16'sh7fff;
    if (x < SAT_MIN) return 16'sh8000;
    return x[15:0];
  endfunction

endpackage

// File: rtl/alveo_hls4ml_mul_share_rr_arb.sv
// rtl/alveo_hls4ml_mul_share_rr_arb.sv - round-robin pick of the first request at or after the pointer
module alveo_hls4ml_mul_share_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alveo_hls4ml_mul_share_sched.sv
// rtl/alveo_hls4ml_mul_share_sched.sv - shares one 4-stage signed 16x14 multiplier among NREQ requesters
// Optional saturating output selected by MUL_SHARE_SAT_EN.
module alveo_hls4ml_mul_share_sched
  import alveo_hls4ml_mul_share_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDX_W     = 2,
  parameter int SAT_SHIFT = 10
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDX_W-1:0]    res_id,
  output logic [P_W-1:0]      res_p,
  output logic                busy
);

`ifdef MUL_SHARE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  stage_t [LAT-1:0] st;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [NREQ-1:0]  gnt;
  logic             any_req;
  logic             ce;
  logic             issue;
  logic [A_W-1:0]   a_sel;
  logic [B_W-1:0]   b_sel;

  alveo_hls4ml_mul_share_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx),
    .found (any_req)
  );

  // One enable freezes the whole pipe, so a stalled output also blocks new grants.
  assign res_valid = st[LAT-1].valid;
  assign ce        = ~res_valid | res_ready;
  assign issue     = ap_rst_n & ce & any_req;
  assign req_ready = issue ? gnt : '0;
  assign res_id    = st[LAT-1].id[IDX_W-1:0];
  assign res_p     = st[LAT-1].p;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*A_W +: A_W];
        b_sel = req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | st[k].valid;
  end

  function automatic stage_t mul_stage(input stage_t s);
    stage_t o;
    o   = s;
    o.p = mul_ab($signed(s.a), $signed(s.b));
    return o;
  endfunction

  // Saturation lives in the output register so latency is unchanged.
  function automatic stage_t out_stage(input stage_t s);
    stage_t                o;
    logic signed [P_W-1:0] sh;
    logic signed [P_W-1:0] sat;
    o   = s;
    sh  = $signed(s.p) >>> SAT_SHIFT;
    sat = P_W'(sat16(sh));
    o.p = SAT_ON ? sat : s.p;
    return o;
  endfunction

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      st  <= '0;
      ptr <= '0;
    end else if (ce) begin
      st[0] <= '{valid: issue, id: ID_MAX_W'(gidx), a: a_sel, b: b_sel, p: '0};
      st[1] <= mul_stage(st[0]);
      for (int k = 2; k < LAT-1; k++) st[k] <= st[k-1];
      st[LAT-1] <= out_stage(st[LAT-2]);
      if (issue) ptr <= (gidx == IDX_W'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alveo_hls4ml_mul_share_sched.sv
// tb/tb_alveo_hls4ml_mul_share_sched.sv - directed self-checking bench for the shared multiplier scheduler
module tb_alveo_hls4ml_mul_share_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [55:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [29:0] res_p;
  logic        busy;

  int nchecks = 0;
  int nerrors = 0;

  always #5 ap_clk = ~ap_clk;

  alveo_hls4ml_mul_share_sched #(
    .NREQ      (4),
    .IDX_W     (2),
    .SAT_SHIFT (10)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy)
  );

  typedef struct {
    int     id;
    longint p;
  } exp_t;

  exp_t   q[$];
  int     lane_a[4] = '{100, -200, 1234, -32768};
  int     lane_b[4] = '{-7, 33, -8192, -8192};
  longint raw_p[4]  = '{-700, -6600, -10108928, 268435456};
  longint sat_p[4]  = '{-1, -7, -9872, 32767};
  int     exp_g;
  int     issued;
  int     popped;

  function automatic longint pick(input longint raw, input longint sat);
`ifdef MUL_SHARE_SAT_EN
    return sat;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pack_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(lane_a[i]);
      req_b[i*14 +: 14] = 14'(lane_b[i]);
    end
  endtask

  task automatic sb_sample();
    logic [3:0] hs;
    logic [3:0] eg;
    @(negedge ap_clk);
    hs = req_ready & req_valid;
    if (hs != 4'b0) begin
      eg = 4'(1 << exp_g);
      check("grant", hs, eg);
      q.push_back('{exp_g, pick(raw_p[exp_g], sat_p[exp_g])});
      exp_g = (exp_g + 1) % 4;
      issued++;
    end
    if (res_valid) begin
      if (q.size() == 0) check("sb_extra", q.size(), 1);
      else begin
        check("sb_id", res_id, q[0].id);
        check("sb_p", $signed(res_p), q[0].p);
        if (res_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  endtask

  task automatic single_op(input int lane, input int a, input int b, input longint raw, input longint sat);
    logic [3:0] oh;
    oh = 4'(1 << lane);
    req_a[lane*16 +: 16] = 16'(a);
    req_b[lane*14 +: 14] = 14'(b);
    req_valid = oh;
    @(negedge ap_clk);
    check("op_ready", req_ready, oh);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge ap_clk);
      if (k < 4) check("op_early", res_valid, 0);
      else begin
        check("op_valid", res_valid, 1);
        check("op_id", res_id, lane);
        check("op_p", $signed(res_p), pick(raw, sat));
      end
      tick();
    end
    pack_ops();
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    exp_g     = 0;
    issued    = 0;
    popped    = 0;
    pack_ops();
    tick();

    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_p", res_p, 0);
      tick();
    end
    ap_rst_n  = 1'b1;
    req_valid = '0;
    tick();

    single_op(2, -3, 5, -15, -1);

    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    q.delete();
    exp_g = 0;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8) ? 4'hf : 4'h0;
      sb_sample();
      if (c >= 4 && c < 12) check("rot_nogap", res_valid, 1);
      else check("rot_idle", res_valid, 0);
      tick();
    end
    check("rot_q_empty", q.size(), 0);

    issued = 0;
    popped = 0;
    for (int c = 0; c < 22; c++) begin
      req_valid = (c < 10) ? 4'hf : 4'h0;
      res_ready = (c >= 5 && c < 8) ? 1'b0 : 1'b1;
      sb_sample();
      if (c >= 5 && c < 8) begin
        check("stall_req_ready", req_ready, 0);
        check("stall_res_valid", res_valid, 1);
      end
      tick();
    end
    check("stall_issued", issued, 7);
    check("stall_popped", popped, 7);
    check("stall_q_empty", q.size(), 0);
    check("stall_busy", busy, 0);

    single_op(3, -32768, -8192, 268435456, 32767);

    req_valid = '1;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    @(negedge ap_clk);
    check("flight_busy", busy, 1);
    check("flight_no_res", res_valid, 0);
    tick();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      check("post_rst_valid", res_valid, 0);
      check("post_rst_busy", busy, 0);
      tick();
    end

    single_op(1, 7, -9, -63, -1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
